// File: rtl/data_sync_pulse_pkg.sv
// rtl/data_sync_pulse_pkg.sv - shared constants for the qualifier-enable data synchroniser
package data_sync_pulse_pkg;

  localparam int MODE_LEVEL      = 0;
  localparam int MODE_TOGGLE     = 1;

  localparam int NUM_STAGES_MIN  = 2;
  localparam int NUM_STAGES_MAX  = 8;

endpackage

// File: rtl/data_sync_pulse_sync_chain.sv
// rtl/data_sync_pulse_sync_chain.sv - single-bit flop chain synchroniser, async active-low reset
module data_sync_pulse_sync_chain #(
  parameter int NUM_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic sync_out
);

  logic [NUM_STAGES-1:0] stage_q;
  logic [NUM_STAGES-1:0] stage_d;

  always_comb begin
    stage_d = {stage_q[NUM_STAGES-2:0], d_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign sync_out = stage_q[NUM_STAGES-1];

endmodule

// File: rtl/data_sync_pulse.sv
// rtl/data_sync_pulse.sv - captures a quasi-static bus on an edge of the synchronised qualifier
module data_sync_pulse
  import data_sync_pulse_pkg::*;
#(
  parameter int NUM_STAGES  = 2,
  parameter int BUS_WIDTH   = 8,
  parameter int TOGGLE_MODE = MODE_LEVEL,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
  input  logic                 BUS_ENABLE,
  output logic [BUS_WIDTH-1:0] SYNC_BUS,
  output logic                 ENABLE_PULSE,
  output logic [CNT_WIDTH-1:0] CAPTURE_CNT
);

  logic                 sync_en;
  logic                 cap;
  logic                 en_q;
  logic                 en_d;
  logic [BUS_WIDTH-1:0] sync_bus_q;
  logic [BUS_WIDTH-1:0] sync_bus_d;
  logic                 pulse_q;
  logic                 pulse_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  data_sync_pulse_sync_chain #(
    .NUM_STAGES (NUM_STAGES)
  ) u_sync_chain (
    .clk      (CLK),
    .rst_n    (RST),
    .d_in     (BUS_ENABLE),
    .sync_out (sync_en)
  );

  // en_q resets to 0, so an enable already high at reset release still captures once
  always_comb begin
    en_d       = sync_en;
    cap        = (TOGGLE_MODE == MODE_TOGGLE) ? (sync_en ^ en_q) : (sync_en & ~en_q);
    sync_bus_d = sync_bus_q;
    pulse_d    = 1'b0;
    cnt_d      = cnt_q;
    if (cap) begin
      sync_bus_d = UNSYNC_BUS;
      pulse_d    = 1'b1;
      cnt_d      = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      en_q       <= 1'b0;
      sync_bus_q <= '0;
      pulse_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      en_q       <= en_d;
      sync_bus_q <= sync_bus_d;
      pulse_q    <= pulse_d;
      cnt_q      <= cnt_d;
    end
  end

  assign SYNC_BUS     = sync_bus_q;
  assign ENABLE_PULSE = pulse_q;
  assign CAPTURE_CNT  = cnt_q;

endmodule
